// File: rtl/readout_seq_if.sv
// readout_seq_if: sample-RAM read port plus the outgoing sample stream.
//   master (sequencer): drives mem_rd, mem_addr, out_data, out_valid;
//                       samples mem_data, out_ready.
//   slave (RAM + consumer): drives mem_data, out_ready.
interface readout_seq_if;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic [3:0]  mem_data;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_rd, mem_addr, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_data, out_valid,
    output mem_data, out_ready
  );
endinterface

// File: rtl/readout_seq.sv
// readout_seq: frame readout sequencer for the 4-channel capture memory.
// Latches zoom/offset on start, steps an external read-address generator once
// per sample, issues single-cycle RAM reads, waits MEM_LAT cycles and presents
// each 4-bit sample on a valid/ready stream.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, zoom_in, offset_in frame request and its configuration
//   abort                    frame cancel (only with RDSEQ_ABORT_EN defined)
//   ra_old/ra_zoom/ra_offset operands to the address generator
//   ra_next                  generator result (combinational from ra_*)
//   bus                      RAM read port + output stream (readout_seq_if)
//   busy, done, cfg_err      status: non-idle, completion pulse, sticky bad zoom
// Macro RDSEQ_ABORT_EN adds the abort port and its cancel behaviour.
module readout_seq #(
  parameter int unsigned SAMPLES = 256,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          zoom_in,
  input  logic [2:0]          offset_in,
`ifdef RDSEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic [12:0]         ra_old,
  output logic [3:0]          ra_zoom,
  output logic [2:0]          ra_offset,
  input  logic [12:0]         ra_next,
  readout_seq_if.master       bus,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int unsigned AW = 13;
  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   idx, idx_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [LW-1:0]   lat, lat_nxt;
  logic [3:0]      zoom_nxt;
  logic [2:0]      off_nxt;
  logic            err_nxt;
  logic [3:0]      data_nxt;
  logic            zoom_legal;
  logic [3:0]      zoom_sel;

  assign zoom_legal = (zoom_in == 4'd1) || (zoom_in == 4'd2) ||
                      (zoom_in == 4'd4) || (zoom_in == 4'd8);
  assign zoom_sel   = zoom_legal ? zoom_in : 4'd1;

  assign ra_old = idx;

  // Generator result is the read address; forced to 0 outside the read strobe.
  assign bus.mem_addr = bus.mem_rd ? ra_next : '0;

  // Next-state and datapath next values.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    lat_nxt   = lat;
    zoom_nxt  = ra_zoom;
    off_nxt   = ra_offset;
    err_nxt   = cfg_err;
    data_nxt  = bus.out_data;
    case (state)
      IDLE: begin
        if (start) begin
          zoom_nxt  = zoom_sel;
          off_nxt   = offset_in;
          err_nxt   = !zoom_legal;
          // Pre-decrement so the first generator step lands on {offset,8'b0}.
          idx_nxt   = AW'(0) - AW'(zoom_sel);
          cnt_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // Keep idx offset-free; the generator re-adds the page offset.
        idx_nxt   = ra_next - {ra_offset, 8'b0};
        lat_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat == LW'(MEM_LAT - 1)) begin
          data_nxt  = bus.mem_data;
          state_nxt = PRESENT;
        end else begin
          lat_nxt = lat + LW'(1);
        end
      end
      PRESENT: begin
        if (bus.out_ready) begin
          if (cnt == AW'(SAMPLES - 1)) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = cnt + AW'(1);
            state_nxt = ISSUE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef RDSEQ_ABORT_EN
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
    end
`endif
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      lat           <= '0;
      ra_zoom       <= 4'd1;
      ra_offset     <= '0;
      cfg_err       <= 1'b0;
      bus.out_data  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      idx           <= idx_nxt;
      cnt           <= cnt_nxt;
      lat           <= lat_nxt;
      ra_zoom       <= zoom_nxt;
      ra_offset     <= off_nxt;
      cfg_err       <= err_nxt;
      bus.out_data  <= data_nxt;
      bus.mem_rd    <= (state_nxt == ISSUE);
      bus.out_valid <= (state_nxt == PRESENT);
      busy          <= (state_nxt != IDLE);
      done          <= (state_nxt == DONE);
    end
  end

endmodule
